// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the Turtle CPU core: produces the core clock enable
// and sequences free run, halt, N-instruction stepping and PC breakpoints.
module cpu_run_ctrl #(
  parameter int unsigned I_ADDR_W   = 12,
  parameter int unsigned NUM_BP     = 4,
  parameter int unsigned STEP_CNT_W = 16,
  parameter int unsigned RETIRE_W   = 32,
  localparam int unsigned BP_IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run_btn,
  input  logic                         step_btn,
  input  logic                         halt_btn,
  input  logic [STEP_CNT_W-1:0]        step_count,
  input  logic [I_ADDR_W-1:0]          pc,
  input  logic [NUM_BP*I_ADDR_W-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]            bp_enable,
  output logic                         cpu_en,
  output logic [1:0]                   run_state,
  output logic                         bp_hit,
  output logic [BP_IDX_W-1:0]          bp_index,
  output logic [STEP_CNT_W-1:0]        steps_remaining,
  output logic [RETIRE_W-1:0]          retired_count
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_STEP = 1;
  localparam int unsigned BTN_HALT = 2;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_BREAK    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_BTN-1:0]      r_btn_s1;
  logic [NUM_BTN-1:0]      r_btn_s2;
  logic [NUM_BTN-1:0]      r_btn_s3;
  logic [NUM_BTN-1:0]      w_btn_pulse;
  logic                    w_run_pulse;
  logic                    w_step_pulse;
  logic                    w_halt_pulse;
  logic                    r_skip_bp;
  logic                    w_skip_bp_nxt;
  logic                    r_bp_hit;
  logic                    w_bp_hit_nxt;
  logic [BP_IDX_W-1:0]     r_bp_index;
  logic [BP_IDX_W-1:0]     w_bp_index_nxt;
  logic [STEP_CNT_W-1:0]   r_steps;
  logic [STEP_CNT_W-1:0]   w_steps_nxt;
  logic [STEP_CNT_W-1:0]   w_step_load;
  logic [RETIRE_W-1:0]     r_retired;
  logic                    w_match;
  logic [BP_IDX_W-1:0]     w_match_idx;
  logic                    w_active;
  logic                    w_bp_stop;
  logic                    w_cpu_en;

  // Two-flop synchroniser plus edge register for each button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_s3 <= '0;
    end else begin
      r_btn_s1 <= {halt_btn, step_btn, run_btn};
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  assign w_btn_pulse  = r_btn_s2 & ~r_btn_s3;
  assign w_run_pulse  = w_btn_pulse[BTN_RUN];
  assign w_step_pulse = w_btn_pulse[BTN_STEP];
  assign w_halt_pulse = w_btn_pulse[BTN_HALT];

  // Breakpoint compare; descending scan so the lowest matching index wins
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_enable[i] && (pc == bp_addr[i*I_ADDR_W +: I_ADDR_W])) begin
        w_match     = 1'b1;
        w_match_idx = BP_IDX_W'(i);
      end
    end
  end

  // A step request of zero still executes one instruction
  assign w_step_load = (step_count == '0) ? STEP_CNT_W'(1) : step_count;

  // Core enable: executing state, no halt arriving, no unmasked breakpoint at pc
  assign w_active  = (r_state == ST_RUNNING) || (r_state == ST_STEPPING);
  assign w_bp_stop = w_match && !r_skip_bp;
  assign w_cpu_en  = w_active && !w_halt_pulse && !w_bp_stop;

  // State register and run/step bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_HALTED;
      r_skip_bp  <= 1'b0;
      r_bp_hit   <= 1'b0;
      r_bp_index <= '0;
      r_steps    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_bp  <= w_skip_bp_nxt;
      r_bp_hit   <= w_bp_hit_nxt;
      r_bp_index <= w_bp_index_nxt;
      r_steps    <= w_steps_nxt;
    end
  end

  // Next state: halt > breakpoint > step > run
  always_comb begin
    w_state_nxt    = r_state;
    w_skip_bp_nxt  = r_skip_bp;
    w_bp_hit_nxt   = r_bp_hit;
    w_bp_index_nxt = r_bp_index;
    w_steps_nxt    = r_steps;
    case (r_state)
      ST_HALTED, ST_BREAK: begin
        if (w_step_pulse) begin
          w_state_nxt   = ST_STEPPING;
          w_steps_nxt   = w_step_load;
          w_skip_bp_nxt = 1'b1;
          w_bp_hit_nxt  = 1'b0;
        end else if (w_run_pulse) begin
          w_state_nxt   = ST_RUNNING;
          w_skip_bp_nxt = 1'b1;
          w_bp_hit_nxt  = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (w_halt_pulse) begin
          w_state_nxt = ST_HALTED;
        end else if (w_bp_stop) begin
          w_state_nxt    = ST_BREAK;
          w_bp_hit_nxt   = 1'b1;
          w_bp_index_nxt = w_match_idx;
        end else begin
          w_skip_bp_nxt = 1'b0;
        end
      end
      ST_STEPPING: begin
        if (w_halt_pulse) begin
          w_state_nxt = ST_HALTED;
        end else if (w_bp_stop) begin
          w_state_nxt    = ST_BREAK;
          w_bp_hit_nxt   = 1'b1;
          w_bp_index_nxt = w_match_idx;
        end else begin
          w_skip_bp_nxt = 1'b0;
          w_steps_nxt   = r_steps - STEP_CNT_W'(1);
          if (r_steps == STEP_CNT_W'(1)) begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HALTED;
      end
    endcase
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= '0;
    end else if (w_cpu_en) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign cpu_en          = w_cpu_en;
  assign run_state       = r_state;
  assign bp_hit          = r_bp_hit;
  assign bp_index        = r_bp_index;
  assign steps_remaining = r_steps;
  assign retired_count   = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a task-level model predicts where each
// run/step command stops; a monitor compares whenever the controller stops.
module tb_cpu_run_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned NB = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned RW = 4;

  logic              clk;
  logic              reset_n;
  logic              run_btn, step_btn, halt_btn;
  logic [SW-1:0]     step_count;
  logic [AW-1:0]     pc;
  logic [NB*AW-1:0]  bp_addr;
  logic [NB-1:0]     bp_enable;
  logic              cpu_en;
  logic [1:0]        run_state;
  logic              bp_hit;
  logic [1:0]        bp_index;
  logic [SW-1:0]     steps_remaining;
  logic [RW-1:0]     retired_count;

  cpu_run_ctrl #(.I_ADDR_W(AW), .NUM_BP(NB), .STEP_CNT_W(SW), .RETIRE_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .run_btn(run_btn), .step_btn(step_btn),
    .halt_btn(halt_btn), .step_count(step_count), .pc(pc), .bp_addr(bp_addr),
    .bp_enable(bp_enable), .cpu_en(cpu_en), .run_state(run_state), .bp_hit(bp_hit),
    .bp_index(bp_index), .steps_remaining(steps_remaining), .retired_count(retired_count)
  );

  typedef struct {
    int state;
    int retired;
    int steps;
    int hit;
    int idx;
    int pcv;
    int en_total;
  } exp_t;

  exp_t sb_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Model state (what the spec says the system looks like between commands)
  logic [AW-1:0] m_pc;
  int            m_total;
  int            m_steps;
  int            m_idx;
  logic [AW-1:0] m_bp_a[NB];
  bit            m_bp_e[NB];

  // Core model: single-cycle CPU, pc advances by 2 per enabled clock
  int en_total;
  bit en_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    pc = '0;
    en_total = 0;
    forever begin
      @(negedge clk);
      en_s = cpu_en;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pc = '0;
        en_total = 0;
      end else if (en_s) begin
        pc = pc + AW'(2);
        en_total++;
      end
    end
  end

  // Monitor: the controller presents a result when it leaves RUNNING/STEPPING
  initial begin
    int   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 0;
      end else begin
        if ((prev == 1 || prev == 2) && (run_state == 2'd0 || run_state == 2'd3)) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_stop", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("run_state", run_state, e.state);
            chk("retired_count", retired_count, e.retired);
            chk("steps_remaining", steps_remaining, e.steps);
            chk("bp_hit", bp_hit, e.hit);
            if (e.hit != 0) chk("bp_index", bp_index, e.idx);
            chk("pc", pc, e.pcv);
            chk("cpu_en_cycles", en_total, e.en_total);
            chk("cpu_en_after_stop", cpu_en, 0);
          end
        end
        prev = int'(run_state);
      end
    end
  end

  function automatic bit bp_match(input logic [AW-1:0] p, output int idx);
    idx = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_bp_e[i] && m_bp_a[i] == p) begin
        idx = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Instructions retired before stopping; the first one is never blocked
  function automatic int until_stop(input logic [AW-1:0] start, input int limit,
                                    output bit broke, output int idx);
    broke = 1'b0;
    idx = 0;
    for (int k = 1; k < limit; k++) begin
      if (bp_match(start + AW'(2 * k), idx)) begin
        broke = 1'b1;
        return k;
      end
    end
    return limit;
  endfunction

  task automatic expect_stop(input bit broke, input int k, input int idx,
                             input bit is_step, input int n_load);
    exp_t e;
    m_total += k;
    m_pc = m_pc + AW'(2 * k);
    if (is_step) m_steps = broke ? (n_load - k) : 0;
    if (broke) m_idx = idx;
    e.state = broke ? 3 : 0;
    e.retired = m_total % (1 << RW);
    e.steps = m_steps;
    e.hit = broke ? 1 : 0;
    e.idx = m_idx;
    e.pcv = int'(m_pc);
    e.en_total = m_total;
    sb_q.push_back(e);
  endtask

  task automatic apply_bps();
    for (int i = 0; i < NB; i++) begin
      bp_addr[i*AW +: AW] = m_bp_a[i];
      bp_enable[i] = m_bp_e[i];
    end
  endtask

  task automatic wait_drain_release();
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (sb_q.size() != 0) begin
      chk("stop_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    run_btn = 1'b0;
    step_btn = 1'b0;
    halt_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_pc = '0;
    m_total = 0;
    m_steps = 0;
    m_idx = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd_step(input int n);
    bit broke;
    int idx, k, load;
    load = (n == 0) ? 1 : n;
    k = until_stop(m_pc, load, broke, idx);
    expect_stop(broke, k, idx, 1'b1, load);
    step_count = SW'(n);
    step_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("stepping_at_e3", run_state, 2);
    wait_drain_release();
  endtask

  task automatic cmd_run();
    bit broke;
    int idx, k;
    k = until_stop(m_pc, 100000, broke, idx);
    if (!broke) return;
    expect_stop(broke, k, idx, 1'b0, 0);
    run_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("running_at_e3", run_state, 1);
    wait_drain_release();
  endtask

  // Run, then halt w cycles after the run press; halt and run rise together
  task automatic cmd_run_halt(input int w);
    bit broke;
    int idx, k;
    k = until_stop(m_pc, w - 1, broke, idx);
    expect_stop(broke, k, idx, 1'b0, 0);
    run_btn = 1'b1;
    repeat (2) @(negedge clk);
    run_btn = 1'b0;
    @(negedge clk);
    chk("running_at_e3", run_state, 1);
    repeat (w - 3) @(negedge clk);
    halt_btn = 1'b1;
    if (!broke) begin
      run_btn = 1'b1;
      repeat (2) @(negedge clk);
      chk("cpu_en_in_halt_pulse", cpu_en, 0);
      chk("state_in_halt_pulse", run_state, 1);
    end
    wait_drain_release();
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0;
    run_btn = 1'b0;
    step_btn = 1'b0;
    halt_btn = 1'b0;
    step_count = '0;
    bp_addr = '0;
    bp_enable = '0;
    for (int i = 0; i < NB; i++) begin
      m_bp_a[i] = '0;
      m_bp_e[i] = 1'b0;
    end
    #1;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_run_state", run_state, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_steps", steps_remaining, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_bp_index", bp_index, 0);
    do_reset();

    // Idle: nothing executes without a button
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_en) cnt++;
    end
    chk("idle_cpu_en_cycles", cnt, 0);
    chk("idle_run_state", run_state, 0);
    chk("idle_retired", retired_count, 0);

    // Three-instruction step
    cmd_step(3);

    // Breakpoint 1 at 0x010, then single step off it with step_count=0
    do_reset();
    m_bp_a[1] = 12'h010;
    m_bp_e[1] = 1'b1;
    apply_bps();
    cmd_run();
    cmd_step(0);

    // Resume from a breakpoint without re-breaking
    do_reset();
    cmd_run();
    cmd_run_halt(8);

    // Halt while running, with run rising in the same clock
    m_bp_e[1] = 1'b0;
    apply_bps();
    cmd_run_halt(10);

    // Reset in the middle of a long step
    step_count = SW'(50);
    step_btn = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_step_state", run_state, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cpu_en", cpu_en, 0);
    chk("async_rst_state", run_state, 0);
    chk("async_rst_retired", retired_count, 0);
    chk("async_rst_steps", steps_remaining, 0);
    chk("async_rst_bp_hit", bp_hit, 0);
    chk("async_rst_bp_index", bp_index, 0);
    step_btn = 1'b0;
    do_reset();

    // Counter wrap, then two simultaneous matches
    cmd_run_halt(18);
    m_bp_a[0] = 12'h040;
    m_bp_a[2] = 12'h040;
    m_bp_e[0] = 1'b1;
    m_bp_e[2] = 1'b1;
    apply_bps();
    cmd_run();

    // Random commands and breakpoint sets
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int sel;
      bit broke;
      int idx;
      int k;
      if (r % 3 == 0) begin
        for (int i = 0; i < NB; i++) begin
          m_bp_e[i] = bit'($urandom_range(0, 1));
          m_bp_a[i] = m_pc + AW'(2 * $urandom_range(0, 20))
                      + AW'(($urandom_range(0, 5) == 0) ? 1 : 0);
        end
        apply_bps();
      end
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        cmd_step(int'($urandom_range(0, 8)));
      end else begin
        k = until_stop(m_pc, 100000, broke, idx);
        if (sel == 1 && broke) cmd_run();
        else cmd_run_halt(int'($urandom_range(4, 25)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
